sched_issue_pick: RTL

- Parametrised oldest-first issue picker for one functional-unit class (ALU, shift, mul, branch, ld/st).
- Replaces the per-configuration generated scheduler cores with a single block generalised in NCOMMIT and NUNIT.
- Adds per-unit occupancy for non-pipelined units and an internal issued bitmap.
- Sits between the commit-slot ready logic and the unit operand-read stage; one instance per unit class.

---
 rtl/sched_pkg.sv | 21 ++
 rtl/sched_find_first.sv | 22 ++
 rtl/sched_issue_pick.sv | 114 +++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the oldest-first issue picker.
package sched_pkg;

  localparam int unsigned MAX_NUNIT    = 4;
  localparam int unsigned MAX_UNIT_LAT = 64;
  localparam int unsigned MAX_NCOMMIT  = 1024;

  typedef logic [MAX_NCOMMIT-1:0] slot_vec_t;

  // Rotate the low n bits of v right by sh, so bit sh lands at bit 0.
  function automatic slot_vec_t rot_right(input slot_vec_t v, input int unsigned sh,
                                          input int unsigned n);
    slot_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_NCOMMIT; i++) begin
      if (i < n) r[i] = v[(i + sh) % n];
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_find_first.sv
// Lowest-set-bit finder; one link of the per-unit pick chain.
module sched_find_first #(
  parameter int unsigned N  = 32,
  parameter int unsigned LN = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic          found_c,
  output logic [LN-1:0] idx_c
);

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_c = 1'b1;
        idx_c   = LN'(i);
      end
    end
  end

endmodule

// File: rtl/sched_issue_pick.sv
// Oldest-first issue picker for one unit class with per-unit occupancy.
// Optional SCHED_PERF_EN adds the saturating perf_stall counter port.
module sched_issue_pick
  import sched_pkg::*;
#(
  parameter int unsigned NCOMMIT  = 32,
  parameter int unsigned LNCOMMIT = $clog2(NCOMMIT),
  parameter int unsigned NUNIT    = 2,
  parameter int unsigned UNIT_LAT = 1,
  parameter int unsigned LLAT     = $clog2(UNIT_LAT + 1),
  parameter type         slot_t   = logic [LNCOMMIT-1:0]
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LNCOMMIT-1:0]       commit_start,
  input  logic [NCOMMIT-1:0]        ready,
  input  logic [NCOMMIT-1:0]        alloc,
  input  logic [NCOMMIT-1:0]        kill,
  output logic [NUNIT-1:0]          issue_valid,
  output logic [NUNIT*LNCOMMIT-1:0] issue_addr,
  output logic [NUNIT-1:0]          unit_busy
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]               perf_stall
`endif
);

  if (NUNIT > MAX_NUNIT || UNIT_LAT > MAX_UNIT_LAT || NCOMMIT > MAX_NCOMMIT) begin : g_bad_cfg
    $error("sched_issue_pick: parameter out of range");
  end

  logic [NCOMMIT-1:0]        issued_q, issued_d;
  logic [NCOMMIT-1:0]        elig_c, pick_mask_c;
  logic [NCOMMIT-1:0]        avail_c [NUNIT+1];
  logic [NUNIT-1:0]          pick_v_c;
  slot_t                     pick_slot_c [NUNIT];
  logic [LLAT-1:0]           cnt_q [NUNIT];
  logic [LLAT-1:0]           cnt_d [NUNIT];
  logic [NUNIT-1:0]          unit_busy_d;
  logic [NUNIT*LNCOMMIT-1:0] issue_addr_d;

  // Bit 0 of the rotated vector is the oldest live slot.
  assign elig_c     = ready & ~issued_q & ~alloc & ~kill;
  assign avail_c[0] = NCOMMIT'(rot_right(slot_vec_t'(elig_c), 32'(commit_start), NCOMMIT));

  for (genvar u = 0; u < NUNIT; u++) begin : g_unit
    logic [NCOMMIT-1:0]  req_c;
    logic                found_c;
    logic [LNCOMMIT-1:0] ridx_c;

    assign req_c = (cnt_q[u] == '0) ? avail_c[u] : '0;

    sched_find_first #(.N(NCOMMIT), .LN(LNCOMMIT)) u_ff (
      .vec_i   (req_c),
      .found_c (found_c),
      .idx_c   (ridx_c)
    );

    // Un-rotate: power-of-2 slot count makes the add wrap naturally.
    assign pick_v_c[u]    = found_c;
    assign pick_slot_c[u] = slot_t'(ridx_c + commit_start);
    assign avail_c[u+1]   = avail_c[u] & ~(found_c ? (NCOMMIT'(1) << ridx_c) : '0);
  end

  always_comb begin
    pick_mask_c  = '0;
    issue_addr_d = '0;
    for (int u = 0; u < NUNIT; u++) begin
      if (pick_v_c[u]) begin
        pick_mask_c[pick_slot_c[u]]         = 1'b1;
        issue_addr_d[u*LNCOMMIT +: LNCOMMIT] = pick_slot_c[u];
      end
    end
    issued_d = (issued_q | pick_mask_c) & ~(alloc | kill);
  end

  // Occupancy: load on issue, otherwise count down to idle.
  always_comb begin
    for (int u = 0; u < NUNIT; u++) begin
      cnt_d[u] = '0;
      if (pick_v_c[u])          cnt_d[u] = LLAT'(UNIT_LAT - 1);
      else if (cnt_q[u] != '0)  cnt_d[u] = cnt_q[u] - LLAT'(1);
      unit_busy_d[u] = (cnt_d[u] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q    <= '0;
      issue_valid <= '0;
      issue_addr  <= '0;
      unit_busy   <= '0;
      for (int u = 0; u < NUNIT; u++) cnt_q[u] <= '0;
    end else begin
      issued_q    <= issued_d;
      issue_valid <= pick_v_c;
      issue_addr  <= issue_addr_d;
      unit_busy   <= unit_busy_d;
      for (int u = 0; u < NUNIT; u++) cnt_q[u] <= cnt_d[u];
    end
  end

`ifdef SCHED_PERF_EN
  // Structural stall: something was still eligible after all picks.
  logic stall_c;
  assign stall_c = |avail_c[NUNIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_stall <= '0;
    else if (stall_c && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
  end
`endif

endmodule
